arb8_rr_ctrl: RTL and testbench

ARB8_RR_CTRL -- requirements
Module: arb8_rr_ctrl

---
 rtl/arb8_rr_ctrl_pkg.sv | 18 +
 rtl/arb8_rr_ctrl_if.sv | 24 ++
 rtl/prio_pick8.sv | 24 ++
 rtl/arb8_rr_ctrl.sv | 85 ++++++++
 tb/tb_arb8_rr_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/arb8_rr_ctrl_pkg.sv
// Shared types and sizes for the 8-way round-robin / fixed-priority arbiter.
// Holds the FSM state encoding and a one-hot helper used by the grant register.
package arb8_rr_ctrl_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned HOLD_W  = 4;

  typedef logic [0:0] arb_state_t;

  localparam arb_state_t IDLE  = 1'b0;
  localparam arb_state_t GRANT = 1'b1;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/arb8_rr_ctrl_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface arb8_rr_ctrl_if;
  import arb8_rr_ctrl_pkg::*;

  logic               en;
  logic               mode;
  logic [NUM_REQ-1:0] req;
  logic               rel;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;
  logic               timeout;

  modport master (
    output en, mode, req, rel,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  en, mode, req, rel,
    output gnt, gnt_id, gnt_valid, timeout
  );

endinterface

// File: rtl/prio_pick8.sv
// Combinational winner search: scans ids start-1, start-2, ..., start (mod 8)
// and returns the first asserted one. start=0 degenerates to highest-index-wins.
module prio_pick8
  import arb8_rr_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_vec,
  input  logic [ID_W-1:0]    i_start,
  output logic [ID_W-1:0]    o_id,
  output logic               o_found
);

  always_comb begin
    o_id    = '0;
    o_found = 1'b0;
    // k = NUM_REQ wraps to offset 0, so start itself is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!o_found && i_vec[i_start - ID_W'(k)]) begin
        o_id    = i_start - ID_W'(k);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb8_rr_ctrl.sv
// 8-requester arbiter with fixed-priority or round-robin selection, a hold
// limit with forced revoke, and fully registered grant outputs.
module arb8_rr_ctrl
  import arb8_rr_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input logic           clk,
  input logic           rst_n,
  arb8_rr_ctrl_if.slave bus
);

  arb_state_t         r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [HOLD_W-1:0]  r_hold;
  logic [NUM_REQ-1:0] r_gnt;
  logic [ID_W-1:0]    r_gnt_id;
  logic               r_gnt_valid;
  logic               r_timeout;

  logic [ID_W-1:0]    w_start;
  logic [ID_W-1:0]    w_win_id;
  logic               w_found;
  logic               w_held_req;
  logic               w_hold_hit;
  logic               w_exit;
  logic               w_tmo;

  // mode only matters here, and this path is only consumed in IDLE.
  assign w_start = bus.mode ? r_ptr : '0;

  prio_pick8 u_pick (
    .i_vec   (bus.req),
    .i_start (w_start),
    .o_id    (w_win_id),
    .o_found (w_found)
  );

  always_comb begin
    w_held_req = bus.req[r_gnt_id];
    w_hold_hit = (r_hold == HOLD_W'(HOLD_MAX));
    w_exit     = bus.rel | ~w_held_req | ~bus.en | w_hold_hit;
    w_tmo      = w_hold_hit & ~bus.rel & bus.en & w_held_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_hold      <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (r_state == IDLE) begin
      r_timeout <= 1'b0;
      if (bus.en && w_found) begin
        r_state     <= GRANT;
        r_gnt       <= id_to_onehot(w_win_id);
        r_gnt_id    <= w_win_id;
        r_gnt_valid <= 1'b1;
        r_ptr       <= w_win_id;
        r_hold      <= HOLD_W'(1);
      end
    end else begin
      if (w_exit) begin
        r_state     <= IDLE;
        r_gnt       <= '0;
        r_gnt_id    <= '0;
        r_gnt_valid <= 1'b0;
        r_hold      <= '0;
        r_timeout   <= w_tmo;
      end else begin
        r_hold    <= r_hold + HOLD_W'(1);
        r_timeout <= 1'b0;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_arb8_rr_ctrl.sv
// Self-checking bench for arb8_rr_ctrl: directed scenarios plus random traffic,
// all compared against a transaction-level reference model.
module tb_arb8_rr_ctrl;

  localparam int unsigned HoldMax = 3;

  logic clk;
  logic rst_n;

  arb8_rr_ctrl_if bus_if ();

  arb8_rr_ctrl #(
    .HOLD_MAX (HoldMax)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the grant, for how long, and where RR resumes.
  bit m_busy;
  int m_id;
  int m_held;
  int m_ptr;
  bit m_tmo;

  function automatic int model_pick(input logic [7:0] r, input int start);
    for (int off = 1; off <= 8; off++) begin
      if (r[(start + 8 - off) % 8]) return (start + 8 - off) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_id   = 0;
    m_held = 0;
    m_ptr  = 0;
    m_tmo  = 0;
  endtask

  task automatic model_step(input bit en, input bit mode, input logic [7:0] req, input bit rel);
    int w;
    if (!m_busy) begin
      m_tmo = 0;
      w = model_pick(req, mode ? m_ptr : 0);
      if (en && w >= 0) begin
        m_busy = 1;
        m_id   = w;
        m_held = 1;
        m_ptr  = w;
      end
    end else begin
      if (rel || !req[m_id] || !en || m_held == int'(HoldMax)) begin
        m_tmo  = (m_held == int'(HoldMax)) && !rel && en && req[m_id];
        m_busy = 0;
        m_id   = 0;
        m_held = 0;
      end else begin
        m_held++;
        m_tmo = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".gnt"}, 32'(bus_if.gnt), m_busy ? (32'd1 << m_id) : 32'd0);
    check_eq({tag, ".gnt_id"}, 32'(bus_if.gnt_id), m_busy ? 32'(m_id) : 32'd0);
    check_eq({tag, ".gnt_valid"}, 32'(bus_if.gnt_valid), 32'(m_busy));
    check_eq({tag, ".timeout"}, 32'(bus_if.timeout), 32'(m_tmo));
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic cycle(input string tag, input bit en, input bit mode, input logic [7:0] req,
                       input bit rel);
    bus_if.en   = en;
    bus_if.mode = mode;
    bus_if.req  = req;
    bus_if.rel  = rel;
    model_step(en, mode, req, rel);
    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".gnt"}, 32'(bus_if.gnt), 32'd0);
    check_eq({tag, ".gnt_id"}, 32'(bus_if.gnt_id), 32'd0);
    check_eq({tag, ".gnt_valid"}, 32'(bus_if.gnt_valid), 32'd0);
    check_eq({tag, ".timeout"}, 32'(bus_if.timeout), 32'd0);
  endtask

  initial begin
    int          rr_exp [8];
    logic        r_en;
    logic        r_mode;
    logic [7:0]  r_req;
    logic        r_rel;

    rr_exp = '{4, 3, 2, 1, 0, 7, 6, 5};
    rst_n       = 1'b0;
    bus_if.en   = 1'b0;
    bus_if.mode = 1'b0;
    bus_if.req  = 8'h00;
    bus_if.rel  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Fixed priority picks highest index.
    cycle("fixed", 1'b1, 1'b0, 8'h24, 1'b0);
    check_eq("fixed_gnt", 32'(bus_if.gnt), 32'h20);
    check_eq("fixed_id", 32'(bus_if.gnt_id), 32'd5);

    // Round-robin rotation from ptr=5, one idle gap between grants.
    for (int i = 0; i < 8; i++) begin
      cycle("rr_rel", 1'b1, 1'b1, 8'hFF, 1'b1);
      check_eq("rr_gap", 32'(bus_if.gnt), 32'd0);
      cycle("rr_gnt", 1'b1, 1'b1, 8'hFF, 1'b0);
      check_eq("rr_seq", 32'(bus_if.gnt_id), 32'(rr_exp[i]));
    end
    cycle("rr_end", 1'b1, 1'b0, 8'h00, 1'b1);

    // Hold limit forces a revoke with a timeout pulse.
    for (int i = 0; i < int'(HoldMax); i++) begin
      cycle("hold", 1'b1, 1'b0, 8'h04, 1'b0);
      check_eq("hold_valid", 32'(bus_if.gnt_valid), 32'd1);
    end
    cycle("hold_exit", 1'b1, 1'b0, 8'h04, 1'b0);
    check_eq("tmo_pulse", 32'(bus_if.timeout), 32'd1);
    check_eq("tmo_gnt", 32'(bus_if.gnt), 32'd0);
    cycle("hold_after", 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("tmo_once", 32'(bus_if.timeout), 32'd0);

    // Coincident rel and dropped request: single exit, no timeout.
    cycle("co_gnt", 1'b1, 1'b0, 8'h48, 1'b0);
    check_eq("co_id6", 32'(bus_if.gnt_id), 32'd6);
    cycle("co_exit", 1'b1, 1'b0, 8'h08, 1'b1);
    check_eq("co_tmo", 32'(bus_if.timeout), 32'd0);
    check_eq("co_gap", 32'(bus_if.gnt), 32'd0);
    cycle("co_regnt", 1'b1, 1'b0, 8'h08, 1'b0);
    check_eq("co_id3", 32'(bus_if.gnt_id), 32'd3);
    cycle("co_end", 1'b1, 1'b0, 8'h00, 1'b0);

    // Enable low revokes and blocks new grants.
    cycle("en_gnt", 1'b1, 1'b0, 8'h81, 1'b0);
    check_eq("en_id7", 32'(bus_if.gnt_id), 32'd7);
    for (int i = 0; i < 4; i++) begin
      cycle("en_low", 1'b0, 1'b0, 8'h81, 1'b0);
      check_eq("en_low_gnt", 32'(bus_if.gnt), 32'd0);
    end

    // Asynchronous reset mid-grant, then ptr must be back at 0.
    cycle("rst_gnt", 1'b1, 1'b1, 8'h81, 1'b0);
    check_eq("rst_pre_valid", 32'(bus_if.gnt_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 1'b1, 8'h03, 1'b0);
    check_eq("post_rst_id", 32'(bus_if.gnt_id), 32'd1);

    // Random traffic; holder's request is often kept up so timeouts occur.
    for (int c = 0; c < 800; c++) begin
      r_en   = ($urandom % 8) != 0;
      r_mode = 1'($urandom % 2);
      r_req  = 8'($urandom) & 8'($urandom);
      if (m_busy && ($urandom % 4) != 0) r_req[m_id] = 1'b1;
      r_rel  = ($urandom % 5) == 0;
      cycle("rand", r_en, r_mode, r_req, r_rel);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
